// File: rtl/rl_scfifo_wrarb_pkg.sv
// Shared types and helpers for the packet-atomic round-robin FIFO write arbiter.
// Optional stall timeout is enabled with RL_SCFIFO_WRARB_TIMEOUT_EN.
package rl_scfifo_wrarb_pkg;

    localparam int MAX_REQ = 16;
    localparam int MAX_IDX = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // First set request strictly after ptr, wrapping at n; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                     input logic [MAX_IDX-1:0] ptr,
                                                     input int n);
        logic [MAX_REQ-1:0] sel;
        logic               found;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i <= n && !found && req[idx[3:0]]) begin
                sel[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [MAX_IDX-1:0] onehot2bin(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) bin = bin | MAX_IDX'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/rl_scfifo_wrarb_if.sv
// Producer handshakes plus FIFO write port of rl_scfifo_wrarb.
// Handshake: a beat moves on a cycle where req_valid_i[k] & req_ready_o[k] at the clock edge.
interface rl_scfifo_wrarb_if #(
    parameter int REQUESTERS = 4,
    parameter int DATA_SIZE  = 32,
    parameter int PTR_SIZE   = 4
);
    logic [REQUESTERS-1:0]           req_valid_i;
    logic [REQUESTERS-1:0]           req_last_i;
    logic [REQUESTERS*DATA_SIZE-1:0] req_data_i;
    logic [REQUESTERS-1:0]           req_ready_o;
    logic [REQUESTERS-1:0]           grant_o;
    logic                            busy_o;
    logic [DATA_SIZE-1:0]            fifo_d_o;
    logic                            fifo_wrena_o;
    logic [PTR_SIZE:0]               fifo_usedw_i;
    logic                            err_o;

    modport master (
        output req_valid_i, req_last_i, req_data_i, fifo_usedw_i,
        input  req_ready_o, grant_o, busy_o, fifo_d_o, fifo_wrena_o, err_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, fifo_usedw_i,
        output req_ready_o, grant_o, busy_o, fifo_d_o, fifo_wrena_o, err_o
    );

endinterface

// File: rtl/rl_rr_arbiter.sv
// Combinational round-robin select; the pointer register is held by the parent.
module rl_rr_arbiter
    import rl_scfifo_wrarb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [REQUESTERS-1:0] gnt_o
);

    always_comb begin
        gnt_o = REQUESTERS'(rr_select(MAX_REQ'(req_i), MAX_IDX'(ptr_i), REQUESTERS));
    end

endmodule

// File: rtl/rl_scfifo_wrarb.sv
// Packet-atomic round-robin write arbiter with credit flow control in front of a single-clock FIFO.
// Define RL_SCFIFO_WRARB_TIMEOUT_EN to revoke a grant whose owner stalls for TIMEOUT cycles.
module rl_scfifo_wrarb
    import rl_scfifo_wrarb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_SIZE   = $clog2(FIFO_DEPTH),
    parameter int TIMEOUT    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    rl_scfifo_wrarb_if.slave   bus
);

    localparam int                IDX_W   = $clog2(REQUESTERS);
    localparam int                CNT_W   = PTR_SIZE + 2;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  RST_PTR = IDX_W'(REQUESTERS - 1);

    state_t                state_q, state_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  wrena_q, wrena_d;
    logic [DATA_SIZE-1:0]  data_q, data_d;

    logic [REQUESTERS-1:0] arb_gnt;
    logic [REQUESTERS-1:0] ready;
    logic [IDX_W-1:0]      owner_idx;
    logic                  owner_last;
    logic [DATA_SIZE-1:0]  owner_data;
    logic                  credit_ok;
    logic                  accept;
    logic                  revoke;

    rl_rr_arbiter #(.REQUESTERS(REQUESTERS)) u_arb (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Output process: ready is combinational so a fresh grant can accept on its first LOCKED cycle.
    always_comb begin : output_comb
        owner_idx  = IDX_W'(onehot2bin(MAX_REQ'(grant_q)));
        owner_last = |(bus.req_last_i & grant_q);
        owner_data = bus.req_data_i[owner_idx*DATA_SIZE +: DATA_SIZE];
        // The registered beat is not yet counted in usedw, so reserve a slot for it.
        credit_ok  = (CNT_W'(bus.fifo_usedw_i) + CNT_W'(wrena_q)) < DEPTH_C;
        ready      = (state_q == LOCKED && credit_ok && !clr_i) ? grant_q : '0;
        accept     = |(bus.req_valid_i & ready);
    end

`ifdef RL_SCFIFO_WRARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? 16 : 8;

    logic [TO_W-1:0] stall_q, stall_d;
    logic            err_q, err_d;

    always_comb begin : timeout_comb
        stall_d = '0;
        revoke  = 1'b0;
        if (state_q == LOCKED && !accept) begin
            if (!(|(bus.req_valid_i & grant_q))) begin
                stall_d = stall_q + 1'b1;
                revoke  = (stall_d == TO_W'(TIMEOUT));
            end else begin
                stall_d = stall_q;
            end
        end
        if (clr_i || revoke) stall_d = '0;
        err_d = revoke && !clr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign revoke    = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_comb begin : next_state_comb
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wrena_d = accept;
        data_d  = accept ? owner_data : data_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid_i) begin
                    grant_d = arb_gnt;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if ((accept && owner_last) || revoke) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = RST_PTR;
            wrena_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= RST_PTR;
            wrena_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wrena_q <= wrena_d;
            data_q  <= data_d;
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.grant_o      = grant_q;
    assign bus.busy_o       = (state_q == LOCKED);
    assign bus.fifo_d_o     = data_q;
    assign bus.fifo_wrena_o = wrena_q;

endmodule

// File: tb/tb_rl_scfifo_wrarb.sv
// Scoreboard bench for rl_scfifo_wrarb: producer queues drive beats, expected FIFO writes are queued
// up front in arbitration order and compared as fifo_wrena_o pulses appear.
module tb_rl_scfifo_wrarb;

    localparam int R  = 4;
    localparam int W  = 32;
    localparam int PS = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic clr_i = 1'b0;

    rl_scfifo_wrarb_if #(.REQUESTERS(R), .DATA_SIZE(W), .PTR_SIZE(PS)) bus ();

    rl_scfifo_wrarb #(
        .REQUESTERS (R),
        .DATA_SIZE  (W),
        .FIFO_DEPTH (16),
        .PTR_SIZE   (PS),
        .TIMEOUT    (16)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W:0]   pq[R][$];
    logic         hold[R];
    int           wr_t[$];
    int           cyc;
    int           n_cmp;
    int           n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic drive();
        logic [W:0] b;
        for (int k = 0; k < R; k++) begin
            if (pq[k].size() > 0 && !hold[k]) begin
                b = pq[k][0];
                bus.req_valid_i[k]          = 1'b1;
                bus.req_last_i[k]           = b[W];
                bus.req_data_i[k*W +: W]    = b[W-1:0];
            end else begin
                bus.req_valid_i[k]          = 1'b0;
                bus.req_last_i[k]           = 1'b0;
                bus.req_data_i[k*W +: W]    = '0;
            end
        end
    endtask

    task automatic add_beat(input int k, input logic last, output logic [W-1:0] d);
        d = W'($urandom());
        pq[k].push_back({last, d});
    endtask

    // One clock: monitor and handshake sampling at negedge, producer update just after posedge.
    task automatic step();
        logic [R-1:0] hs;
        logic [W-1:0] e;
        @(negedge clk_i);
        if (bus.fifo_wrena_o) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", 64'(bus.fifo_wrena_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_d", 64'(bus.fifo_d_o), 64'(e));
                wr_t.push_back(cyc);
            end
        end
        hs = bus.req_valid_i & bus.req_ready_o;
        @(posedge clk_i);
        #1;
        cyc++;
        for (int k = 0; k < R; k++) begin
            if (hs[k]) void'(pq[k].pop_front());
        end
        drive();
    endtask

    function automatic bit pending();
        for (int k = 0; k < R; k++) if (pq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pending()) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (2) step();
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] a[3];
        logic [W-1:0] b[3];
        logic [W-1:0] s[R][3];
        logic [W-1:0] g[4];
        logic [W-1:0] e5[5];
        logic [W-1:0] f0;
        int           err_cnt;
        bit           seen_p0;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        for (int k = 0; k < R; k++) hold[k] = 1'b0;
        bus.req_valid_i  = '0;
        bus.req_last_i   = '0;
        bus.req_data_i   = '0;
        bus.fifo_usedw_i = '0;
        apply_reset();

        chk("rst_grant", 64'(bus.grant_o), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_wrena", 64'(bus.fifo_wrena_o), 64'd0);
        chk("rst_fifo_d", 64'(bus.fifo_d_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);

        // Two 3-beat packets from producers 0 and 2, valid together.
        for (int i = 0; i < 3; i++) begin
            add_beat(0, i == 2, a[i]);
            add_beat(2, i == 2, b[i]);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(a[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(b[i]);
        wr_t.delete();
        drive();
        step();
        chk("pkt_grant_p0", 64'(bus.grant_o), 64'h1);
        chk("pkt_ready_p0", 64'(bus.req_ready_o), 64'h1);
        repeat (3) step();
        chk("pkt_bubble_grant", 64'(bus.grant_o), 64'h0);
        chk("pkt_bubble_busy", 64'(bus.busy_o), 64'h0);
        step();
        chk("pkt_grant_p2", 64'(bus.grant_o), 64'h4);
        drain(40);
        if (wr_t.size() == 6) begin
            chk("pkt_gap_a01", 64'(wr_t[1] - wr_t[0]), 64'd1);
            chk("pkt_gap_a12", 64'(wr_t[2] - wr_t[1]), 64'd1);
            chk("pkt_gap_bubble", 64'(wr_t[3] - wr_t[2]), 64'd2);
            chk("pkt_gap_b01", 64'(wr_t[4] - wr_t[3]), 64'd1);
        end else begin
            chk("pkt_write_count", 64'(wr_t.size()), 64'd6);
        end

        // All producers with back-to-back single-beat packets.
        apply_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < R; k++) add_beat(k, 1'b1, s[k][r]);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < R; k++) exp_q.push_back(s[k][r]);
        drive();
        step();
        chk("rr_first_grant", 64'(bus.grant_o), 64'h1);
        drain(80);

        // Credit limit near full.
        apply_reset();
        bus.fifo_usedw_i = 5'd15;
        for (int i = 0; i < 3; i++) begin
            add_beat(1, i == 2, d);
            exp_q.push_back(d);
        end
        drive();
        step();
        chk("cr_grant", 64'(bus.grant_o), 64'h2);
        chk("cr_ready_15", 64'(bus.req_ready_o), 64'h2);
        step();
        chk("cr_wrena", 64'(bus.fifo_wrena_o), 64'd1);
        chk("cr_ready_15p1", 64'(bus.req_ready_o), 64'h0);
        bus.fifo_usedw_i = 5'd16;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cr_full_wrena", 64'(bus.fifo_wrena_o), 64'd0);
            chk("cr_full_ready", 64'(bus.req_ready_o), 64'h0);
        end
        bus.fifo_usedw_i = 5'd14;
        #1;
        chk("cr_ready_14", 64'(bus.req_ready_o), 64'h2);
        drain(40);
        bus.fifo_usedw_i = '0;

        // Synchronous clear after two of five beats.
        apply_reset();
        for (int i = 0; i < 5; i++) add_beat(1, i == 4, e5[i]);
        exp_q.push_back(e5[0]);
        exp_q.push_back(e5[1]);
        drive();
        repeat (3) step();
        clr_i = 1'b1;
        add_beat(0, 1'b1, f0);
        drive();
        #1;
        chk("clr_ready", 64'(bus.req_ready_o), 64'h0);
        step();
        clr_i = 1'b0;
        chk("clr_grant", 64'(bus.grant_o), 64'h0);
        chk("clr_busy", 64'(bus.busy_o), 64'h0);
        chk("clr_wrena", 64'(bus.fifo_wrena_o), 64'd0);
        exp_q.push_back(f0);
        for (int i = 2; i < 5; i++) exp_q.push_back(e5[i]);
        step();
        chk("clr_next_grant", 64'(bus.grant_o), 64'h1);
        drain(40);

        // Asynchronous reset mid-packet with requesters valid.
        apply_reset();
        for (int i = 0; i < 4; i++) add_beat(2, i == 3, g[i]);
        exp_q.push_back(g[0]);
        drive();
        repeat (3) step();
        add_beat(0, 1'b1, f0);
        drive();
        rst_i = 1'b1;
        #1;
        chk("arst_grant", 64'(bus.grant_o), 64'h0);
        chk("arst_ready", 64'(bus.req_ready_o), 64'h0);
        chk("arst_wrena", 64'(bus.fifo_wrena_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        repeat (2) step();
        rst_i = 1'b0;
        exp_q.push_back(f0);
        exp_q.push_back(g[2]);
        exp_q.push_back(g[3]);
        step();
        chk("arst_first_grant", 64'(bus.grant_o), 64'h1);
        drain(40);

        // Owner stalls mid-packet while producer 0 waits.
        apply_reset();
        for (int i = 0; i < 3; i++) add_beat(3, i == 2, g[i]);
        exp_q.push_back(g[0]);
        drive();
        repeat (2) step();
        hold[3] = 1'b1;
        add_beat(0, 1'b1, f0);
        drive();
        err_cnt = 0;
        seen_p0 = 1'b0;
`ifdef RL_SCFIFO_WRARB_TIMEOUT_EN
        exp_q.push_back(f0);
`endif
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus.err_o) err_cnt++;
            if (bus.grant_o == 4'h1) seen_p0 = 1'b1;
        end
`ifdef RL_SCFIFO_WRARB_TIMEOUT_EN
        chk("to_err_pulses", 64'(err_cnt), 64'd1);
        chk("to_p0_granted", 64'(seen_p0), 64'd1);
        hold[3] = 1'b0;
        drive();
        exp_q.push_back(g[1]);
        exp_q.push_back(g[2]);
`else
        chk("stall_err", 64'(err_cnt), 64'd0);
        chk("stall_p0_never", 64'(seen_p0), 64'd0);
        chk("stall_grant", 64'(bus.grant_o), 64'h8);
        chk("stall_busy", 64'(bus.busy_o), 64'd1);
        hold[3] = 1'b0;
        drive();
        exp_q.push_back(g[1]);
        exp_q.push_back(g[2]);
        exp_q.push_back(f0);
`endif
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
